pu_operand_sequencer: RTL and testbench

- Upstream feeder and result collector for processing_unit.
- Holds two FP16 operand vectors (A, B) in local buffers.
- On command, issues each element pair to processing_unit using its start/ready handshake, then stores each product P into a result buffer.
- Gives the host a single "run N products" command in place of per-element start/ready handling.

---
 rtl/ttpu_pkg.sv | 20 ++
 rtl/ttpu_buf_ram.sv | 34 +++
 rtl/pu_operand_sequencer.sv | 146 ++++++++++++++
 tb/tb_pu_operand_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttpu_pkg.sv
// ttpu_pkg: shared FP16 width, sequencer state type and
// FP16 constants for the processing-unit feeder slice.
package ttpu_pkg;

  localparam int FP16_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    FINISH
  } seq_state_t;

  localparam logic [FP16_W-1:0] FP16_ONE   = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_TWO   = 16'h4000;
  localparam logic [FP16_W-1:0] FP16_FOUR  = 16'h4400;
  localparam logic [FP16_W-1:0] FP16_EIGHT = 16'h4800;

endpackage

// File: rtl/ttpu_buf_ram.sv
// ttpu_buf_ram: DEPTH x W buffer, one sync write port and one
// registered read port (re gates it; write-first on collision).
module ttpu_buf_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Forward same-edge writes so a write and a read of
  // the same entry in one cycle return the new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/pu_operand_sequencer.sv
// pu_operand_sequencer: buffers FP16 A/B vectors, feeds them to
// processing_unit by start/ready, stores products P into R.
module pu_operand_sequencer
  import ttpu_pkg::*;
#(
  parameter int DATA_W  = FP16_W,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic              cmd_start,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              pu_start,
  output logic [DATA_W-1:0] pu_a,
  output logic [DATA_W-1:0] pu_b,
  input  logic [DATA_W-1:0] pu_P,
  input  logic              pu_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);

  seq_state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0] len_q, len_d, len_clamp;
  logic [TW-1:0] tcnt_q;
  logic err_q, err_d;
  logic pu_start_q;
  logic last, tmo, res_we;
  logic op_we, op_re;
  logic [2*DATA_W-1:0] op_rdata;

  assign len_clamp = (cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;
  assign last = ({1'b0, idx_q} == len_q - ONE_L);
  assign tmo = (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    err_d = err_q;
    res_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          err_d = 1'b0;
          len_d = len_clamp;
          idx_d = '0;
          state_d = (len_clamp == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: state_d = WAIT;
      WAIT: begin
        // ready beats a timeout landing on the same cycle
        if (pu_ready) begin
          res_we = 1'b1;
          if (last) begin
            state_d = FINISH;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
            state_d = ISSUE;
          end
        end else if (tmo) begin
          err_d = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      tcnt_q <= '0;
      err_q <= 1'b0;
      pu_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      err_q <= err_d;
      pu_start_q <= (state_d == ISSUE);
      tcnt_q <= (state_q == WAIT) ? tcnt_q + TW'(1) : '0;
    end
  end

  // Operand read register doubles as the pu_a/pu_b drivers:
  // loaded only on entry to ISSUE, so it holds through WAIT.
  assign op_we = wr_en && (state_q == IDLE);
  assign op_re = (state_d == ISSUE);

  ttpu_buf_ram #(
    .W    (2*DATA_W),
    .DEPTH(DEPTH),
    .AW   (ADDR_W)
  ) u_op_buf (
    .clk  (clk),
    .reset(reset),
    .we   (op_we),
    .waddr(wr_addr),
    .wdata({wr_a, wr_b}),
    .re   (op_re),
    .raddr(idx_d),
    .rdata(op_rdata)
  );

  ttpu_buf_ram #(
    .W    (DATA_W),
    .DEPTH(DEPTH),
    .AW   (ADDR_W)
  ) u_res_buf (
    .clk  (clk),
    .reset(reset),
    .we   (res_we),
    .waddr(idx_q),
    .wdata(pu_P),
    .re   (1'b1),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign pu_a = op_rdata[2*DATA_W-1:DATA_W];
  assign pu_b = op_rdata[DATA_W-1:0];
  assign pu_start = pu_start_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);
  assign err = err_q;

endmodule

// File: tb/tb_pu_operand_sequencer.sv
// tb_pu_operand_sequencer: vector table, operand scoreboard and a
// behavioural 3+ cycle processing_unit model around the sequencer.
module tb_pu_operand_sequencer;
  import ttpu_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_a = '0;
  logic [DW-1:0] wr_b = '0;
  logic cmd_start = 1'b0;
  logic [AW:0] cmd_len = '0;
  logic busy, done, err, pu_start;
  logic [DW-1:0] pu_a, pu_b, pu_P, rd_data;
  logic pu_ready;
  logic [AW-1:0] rd_addr = '0;

  always #5 clk = ~clk;

  pu_operand_sequencer #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .cmd_start(cmd_start), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .pu_start(pu_start), .pu_a(pu_a), .pu_b(pu_b),
    .pu_P(pu_P), .pu_ready(pu_ready),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] p;
  } vec_t;

  vec_t vec [DEPTH];
  logic [DW-1:0] sa [DEPTH];
  logic [DW-1:0] sb [DEPTH];
  logic [2*DW-1:0] exp_q [$];

  int n_chk = 0;
  int n_pass = 0;
  int nstart = 0;
  int ndone = 0;
  int stab_err = 0;
  int cyc = 0;
  int t_start = 0;
  int t_done = 0;
  logic [2*DW-1:0] cur_ab = '0;
  logic [2*DW-1:0] ex_ab;

  int lat = 3;
  bit never = 1'b0;
  bit stale = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // power-of-two FP16 product: sign xor, exponents add
  function automatic logic [DW-1:0] pmul(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [5:0] e;
    e = 6'(a[14:10]) + 6'(b[14:10]) - 6'd15;
    return {a[15] ^ b[15], e[4:0], 10'b0};
  endfunction

  // PU model: ready stays high until the next start; in stale
  // mode it lingers one extra cycle after start.
  int m_cnt = 0;
  logic m_drop = 1'b0;
  logic [DW-1:0] m_res = '0;

  always @(posedge clk) begin
    if (!reset) begin
      pu_ready <= 1'b0;
      pu_P <= '0;
      m_cnt <= 0;
      m_drop <= 1'b0;
    end else if (pu_start) begin
      m_cnt <= lat;
      m_res <= pmul(pu_a, pu_b);
      m_drop <= stale;
      if (!stale) pu_ready <= 1'b0;
    end else begin
      if (m_drop) begin
        pu_ready <= 1'b0;
        m_drop <= 1'b0;
      end
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !never) begin
          pu_ready <= 1'b1;
          pu_P <= m_res;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pu_start) begin
      nstart++;
      t_start = cyc;
      cur_ab = {pu_a, pu_b};
      if (exp_q.size() == 0) begin
        chk("pu_start_extra", 32'd1, 32'd0);
      end else begin
        ex_ab = exp_q.pop_front();
        chk("pu_ab", {pu_a, pu_b}, ex_ab);
      end
    end else if (busy && ({pu_a, pu_b} != cur_ab)) begin
      stab_err++;
    end
    if (done) begin
      ndone++;
      t_done = cyc;
    end
  end

  task automatic wr_op(input int ad, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_addr = AW'(ad);
    wr_a = a;
    wr_b = b;
    sa[ad] = a;
    sb[ad] = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input int ad, output logic [DW-1:0] d);
    @(posedge clk); #1;
    rd_addr = AW'(ad);
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic run(input int len, input int budget, output int lat_o);
    int n;
    for (int i = 0; i < len && i < DEPTH; i++)
      exp_q.push_back({sa[i], sb[i]});
    nstart = 0;
    ndone = 0;
    stab_err = 0;
    @(posedge clk); #1;
    cmd_start = 1'b1;
    cmd_len = len[AW:0];
    @(posedge clk); #1;
    cmd_start = 1'b0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= budget) chk("done_seen", 32'd0, 32'd1);
    lat_o = n;
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] d;
    int l;
    int k;
    int n;

    vec[0] = '{3'd0, FP16_ONE,  FP16_TWO,   FP16_TWO};
    vec[1] = '{3'd1, FP16_FOUR, FP16_TWO,   FP16_EIGHT};
    vec[2] = '{3'd2, 16'h3800,  FP16_FOUR,  FP16_TWO};
    vec[3] = '{3'd3, 16'hC000,  FP16_TWO,   16'hC400};
    vec[4] = '{3'd4, FP16_EIGHT, FP16_EIGHT, 16'h5400};
    vec[5] = '{3'd5, 16'h3400,  16'h3000,   16'h2800};
    vec[6] = '{3'd6, 16'h4C00,  16'h3800,   FP16_EIGHT};
    vec[7] = '{3'd7, 16'hBC00,  16'hC400,   FP16_FOUR};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pu_start", 32'(pu_start), 32'd0);
    chk("rst_pu_ab", {pu_a, pu_b}, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      wr_op(int'(vec[i].addr), vec[i].a, vec[i].b);

    run(2, 100, l);
    chk("basic_starts", nstart, 2);
    chk("basic_done", ndone, 1);
    chk("basic_err", 32'(err), 32'd0);
    for (int i = 0; i < 2; i++) begin
      rd(i, d);
      chk("basic_r", 32'(d), 32'(vec[i].p));
    end

    run(0, 10, l);
    chk("zero_lat", l, 0);
    chk("zero_starts", nstart, 0);
    chk("zero_done", ndone, 1);

    lat = 10;
    fork
      run(9, 300, l);
      begin
        repeat (20) @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_addr = 3'd7;
        wr_a = 16'h7BFF;
        wr_b = 16'h7BFF;
        cmd_start = 1'b1;
        cmd_len = 4'd1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        cmd_start = 1'b0;
      end
    join
    chk("clamp_starts", nstart, 8);
    chk("clamp_done", ndone, 1);
    chk("clamp_stable", stab_err, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      chk("clamp_r", 32'(d), 32'(vec[i].p));
    end

    for (int i = 0; i < DEPTH; i++)
      wr_op(i, vec[DEPTH-1-i].a, vec[DEPTH-1-i].b);
    lat = 3;
    stale = 1'b1;
    run(8, 200, l);
    chk("stale_starts", nstart, 8);
    chk("stale_stable", stab_err, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      chk("stale_r", 32'(d), 32'(vec[DEPTH-1-i].p));
    end

    stale = 1'b0;
    never = 1'b1;
    run(2, 150, l);
    chk("tmo_starts", nstart, 1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_gap", t_done - t_start, TIMEOUT + 2);
    rd(0, d);
    chk("tmo_r0_kept", 32'(d), 32'(vec[7].p));
    never = 1'b0;
    run(0, 10, l);
    chk("tmo_err_clr", 32'(err), 32'd0);

    wr_op(0, vec[4].a, vec[4].b);
    wr_op(1, vec[5].a, vec[5].b);
    exp_q.push_back({sa[0], sb[0]});
    exp_q.push_back({sa[1], sb[1]});
    @(posedge clk); #1;
    cmd_start = 1'b1;
    cmd_len = 4'd2;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    k = 0;
    n = 0;
    while (k < 2 && n < 100) begin
      @(negedge clk);
      if (pu_start) k++;
      n++;
    end
    chk("rst_run_starts", k, 2);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_pu_start", 32'(pu_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pu_a", 32'(pu_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    rd(0, d);
    chk("mid_rst_r0", 32'(d), 32'(vec[4].p));
    run(2, 100, l);
    chk("rerun_starts", nstart, 2);
    chk("rerun_done", ndone, 1);
    rd(1, d);
    chk("rerun_r1", 32'(d), 32'(vec[5].p));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
